// File: rtl/unidade_controle_jogo.sv
// Moore control FSM for the memory-sequence game, driving the datapath counters and registers.
// Define UC_TIMEOUT_EN to enable the play-window timer and the timeout terminal state.
module unidade_controle_jogo (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       fimRod,
  input  logic       fimT,
  input  logic       igual,
  input  logic       enderecoIgualRodada,
  input  logic       jogada_feita,
  output logic       zeraE,
  output logic       contaE,
  output logic       zeraRod,
  output logic       contaRod,
  output logic       zeraT,
  output logic       contaT,
  output logic       zeraR,
  output logic       registraR,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    StInicial       = 4'h0,
    StPreparacao    = 4'h1,
    StInicioRodada  = 4'h2,
    StEsperaJogada  = 4'h3,
    StRegistra      = 4'h4,
    StComparacao    = 4'h5,
    StProximaJogada = 4'h6,
    StProximaRodada = 4'h7,
    StFimAcertou    = 4'hC,
    StFimErrou      = 4'hD,
    StFimTimeout    = 4'hE
  } estado_e;

  estado_e estado_q, estado_d;

`ifndef UC_TIMEOUT_EN
  logic unused_fimt;
  assign unused_fimt = fimT;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q <= StInicial;
    end else begin
      estado_q <= estado_d;
    end
  end

  always_comb begin
    estado_d = StInicial;
    case (estado_q)
      StInicial:       estado_d = iniciar ? StPreparacao : StInicial;
      StPreparacao:    estado_d = StInicioRodada;
      StInicioRodada:  estado_d = StEsperaJogada;
      StEsperaJogada: begin
        // A captured play takes priority over a simultaneous timer expiry.
        if (jogada_feita) begin
          estado_d = StRegistra;
`ifdef UC_TIMEOUT_EN
        end else if (fimT) begin
          estado_d = StFimTimeout;
`endif
        end else begin
          estado_d = StEsperaJogada;
        end
      end
      StRegistra:      estado_d = StComparacao;
      StComparacao: begin
        if (!igual) begin
          estado_d = StFimErrou;
        end else if (enderecoIgualRodada && fimRod) begin
          estado_d = StFimAcertou;
        end else if (enderecoIgualRodada) begin
          estado_d = StProximaRodada;
        end else begin
          estado_d = StProximaJogada;
        end
      end
      StProximaJogada: estado_d = StEsperaJogada;
      StProximaRodada: estado_d = StInicioRodada;
      StFimAcertou:    estado_d = iniciar ? StPreparacao : StFimAcertou;
      StFimErrou:      estado_d = iniciar ? StPreparacao : StFimErrou;
      StFimTimeout:    estado_d = iniciar ? StPreparacao : StFimTimeout;
      default:         estado_d = StInicial;
    endcase
  end

  always_comb begin
    zeraE     = 1'b0;
    contaE    = 1'b0;
    zeraRod   = 1'b0;
    contaRod  = 1'b0;
    zeraT     = 1'b0;
    contaT    = 1'b0;
    zeraR     = 1'b0;
    registraR = 1'b0;
    pronto    = 1'b0;
    acertou   = 1'b0;
    errou     = 1'b0;
    timeout   = 1'b0;
    db_estado = estado_q;
    case (estado_q)
      StPreparacao: begin
        zeraE   = 1'b1;
        zeraRod = 1'b1;
        zeraR   = 1'b1;
        zeraT   = 1'b1;
      end
      StInicioRodada: begin
        zeraE = 1'b1;
        zeraT = 1'b1;
      end
      StEsperaJogada: begin
`ifdef UC_TIMEOUT_EN
        contaT = 1'b1;
`endif
      end
      StRegistra: begin
        registraR = 1'b1;
        zeraT     = 1'b1;
      end
      StProximaJogada: contaE   = 1'b1;
      StProximaRodada: contaRod = 1'b1;
      StFimAcertou: begin
        pronto  = 1'b1;
        acertou = 1'b1;
      end
      StFimErrou: begin
        pronto = 1'b1;
        errou  = 1'b1;
      end
      StFimTimeout: begin
        pronto = 1'b1;
`ifdef UC_TIMEOUT_EN
        timeout = 1'b1;
`endif
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_unidade_controle_jogo.sv
// Self-checking bench: behavioural datapath plus a game-level play/round model.
module tb_unidade_controle_jogo;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       iniciar = 1'b0;
  logic       fimT = 1'b0;
  logic       igual = 1'b0;
  logic       jogada_feita = 1'b0;
  logic       fimRod, enderecoIgualRodada;
  logic       zeraE, contaE, zeraRod, contaRod, zeraT, contaT, zeraR, registraR;
  logic       pronto, acertou, errou, timeout;
  logic [3:0] db_estado;
  logic [11:0] outs;

  int checks = 0;
  int failures = 0;
  int r = 0;
  int p = 0;
  int ne = 0;
  int nr = 0;
  int base_e, base_r;
  logic [3:0] dp_e = 4'd0;
  logic [3:0] dp_r = 4'd0;

  unidade_controle_jogo dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .fimRod(fimRod), .fimT(fimT),
    .igual(igual), .enderecoIgualRodada(enderecoIgualRodada), .jogada_feita(jogada_feita),
    .zeraE(zeraE), .contaE(contaE), .zeraRod(zeraRod), .contaRod(contaRod),
    .zeraT(zeraT), .contaT(contaT), .zeraR(zeraR), .registraR(registraR),
    .pronto(pronto), .acertou(acertou), .errou(errou), .timeout(timeout),
    .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  // Behavioural datapath: address and round counters driven by the DUT controls.
  always @(posedge clock) begin
    if (zeraE) dp_e <= 4'd0;
    else if (contaE) dp_e <= dp_e + 4'd1;
    if (zeraRod) dp_r <= 4'd0;
    else if (contaRod) dp_r <= dp_r + 4'd1;
    if (contaE) ne <= ne + 1;
    if (contaRod) nr <= nr + 1;
  end

  assign fimRod = (dp_r == 4'd15);
  assign enderecoIgualRodada = (dp_e == dp_r);
  assign outs = {zeraE, contaE, zeraRod, contaRod, zeraT, contaT, zeraR, registraR,
                 pronto, acertou, errou, timeout};

  // Output table: zeraE contaE zeraRod contaRod zeraT contaT zeraR registraR
  //               pronto acertou errou timeout
  function automatic logic [11:0] exp_out(input logic [3:0] st);
    logic [11:0] v;
    v = 12'b0;
    case (st)
      4'h1: v = 12'b1010_1010_0000;
      4'h2: v = 12'b1000_1000_0000;
`ifdef UC_TIMEOUT_EN
      4'h3: v = 12'b0000_0100_0000;
      4'hE: v = 12'b0000_0000_1001;
`else
      4'hE: v = 12'b0000_0000_1000;
`endif
      4'h4: v = 12'b0000_1001_0000;
      4'h6: v = 12'b0100_0000_0000;
      4'h7: v = 12'b0001_0000_0000;
      4'hC: v = 12'b0000_0000_1100;
      4'hD: v = 12'b0000_0000_1010;
      default: v = 12'b0;
    endcase
    return v;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] st);
    logic [11:0] eo;
    eo = exp_out(st);
    checks++;
    assert (db_estado === st) else begin
      failures++;
      $error("FAIL %s state obs=%0h exp=%0h", tag, db_estado, st);
    end
    checks++;
    assert (outs === eo) else begin
      failures++;
      $error("FAIL %s outputs obs=%b exp=%b", tag, outs, eo);
    end
  endtask

  task automatic start_game();
    iniciar = 1'b1;
    step();
    iniciar = 1'b0;
    chk("start_prep", 4'h1);
    step();
    chk("start_rodada", 4'h2);
    step();
    chk("start_espera", 4'h3);
    r = 0;
    p = 0;
  endtask

  // One play from state 3; expected path follows from the round/play indices.
  task automatic do_play(input bit correct, input bit with_fimt);
    int idle;
    idle = $urandom_range(0, 3);
    for (int i = 0; i < idle; i++) begin
      step();
      chk("wait", 4'h3);
    end
    jogada_feita = 1'b1;
    fimT = with_fimt;
    step();
    jogada_feita = 1'b0;
    fimT = 1'b0;
    chk("registra", 4'h4);
    igual = correct;
    step();
    chk("compara", 4'h5);
    step();
    if (!correct) begin
      chk("miss", 4'hD);
    end else if (p == r) begin
      if (r == 15) begin
        chk("win", 4'hC);
      end else begin
        chk("prox_rodada", 4'h7);
        step();
        chk("inicio_rodada", 4'h2);
        step();
        chk("espera_rodada", 4'h3);
        r++;
        p = 0;
      end
    end else begin
      chk("prox_jogada", 4'h6);
      step();
      chk("espera_jogada", 4'h3);
      p++;
    end
    igual = 1'($urandom_range(0, 1));
  endtask

  task automatic hold_terminal(input string tag, input logic [3:0] st);
    for (int i = 0; i < 3; i++) begin
      jogada_feita = 1'($urandom_range(0, 1));
      step();
      chk(tag, st);
    end
    jogada_feita = 1'b0;
  endtask

  initial begin
    #1 reset = 1'b0;
    #1 chk("reset_async", 4'h0);
    step();
    chk("reset_held", 4'h0);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      jogada_feita = 1'($urandom_range(0, 1));
      step();
      chk("idle", 4'h0);
    end
    jogada_feita = 1'b0;

    // Miss on the third play of round 2.
    start_game();
    do_play(1'b1, 1'b0);
    do_play(1'b1, 1'b0);
    do_play(1'b1, 1'b0);
    do_play(1'b1, 1'b0);
    do_play(1'b1, 1'b0);
    do_play(1'b0, 1'b0);
    hold_terminal("miss_hold", 4'hD);
    start_game();

    // Asynchronous reset in the middle of a play window.
    do_play(1'b1, 1'b0);
    #2 reset = 1'b0;
    #1 chk("reset_mid", 4'h0);
    step();
    chk("reset_mid_held", 4'h0);
    reset = 1'b1;
    step();
    chk("reset_release", 4'h0);
    start_game();

    fimT = 1'b1;
`ifdef UC_TIMEOUT_EN
    step();
    fimT = 1'b0;
    chk("timeout", 4'hE);
    hold_terminal("timeout_hold", 4'hE);
    start_game();
`else
    for (int i = 0; i < 3; i++) begin
      step();
      chk("no_timeout", 4'h3);
    end
    fimT = 1'b0;
`endif

    // Full win; first play has fimT raised together with jogada_feita.
    base_e = ne;
    base_r = nr;
    do_play(1'b1, 1'b1);
    while (!(r == 15 && p == 15)) do_play(1'b1, 1'b0);
    do_play(1'b1, 1'b0);
    hold_terminal("win_hold", 4'hC);
    checks++;
    assert ((ne - base_e) === 120) else begin
      failures++;
      $error("FAIL contaE_pulses obs=%0d exp=120", ne - base_e);
    end
    checks++;
    assert ((nr - base_r) === 15) else begin
      failures++;
      $error("FAIL contaRod_pulses obs=%0d exp=15", nr - base_r);
    end
    start_game();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
